// File: rtl/spdif_pkg.sv
// Shared constants for the S/PDIF sub-frame encoder: preamble cell patterns,
// slot positions within a sub-frame, and the sequencer state type.
package spdif_pkg;
  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  localparam int SLOT_AUDIO_LSB     = 4;
  localparam int SLOT_V             = 28;
  localparam int SLOT_U             = 29;
  localparam int SLOT_C             = 30;
  localparam int SLOT_P             = 31;
  localparam int CELLS_PER_SUBFRAME = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/spdif_subframe_assembler.sv
// Builds the 28-bit payload (slots 4..31) and the preamble pattern for one
// sub-frame from a sample's fields.
module spdif_subframe_assembler
  import spdif_pkg::*;
#(
  parameter int AUDIO_WIDTH = 24
) (
  input  logic [AUDIO_WIDTH-1:0] i_audio,
  input  logic                   i_validity,
  input  logic                   i_user,
  input  logic                   i_control,
  input  logic                   i_mute,
  input  logic                   i_is_left,
  input  logic                   i_use_b,
  output logic [27:0]            o_payload,
  output logic [7:0]             o_preamble
);
  logic [23:0] w_audio;
  logic        w_v;

  // Samples narrower than 24 bits are MSB-aligned so the MSB always lands in slot 27.
  assign w_audio = i_mute ? 24'd0 : (24'(i_audio) << (24 - AUDIO_WIDTH));
  assign w_v     = i_validity | i_mute;

  always_comb begin
    o_payload                                 = '0;
    o_payload[23:0]                           = w_audio;
    o_payload[SLOT_V - SLOT_AUDIO_LSB]        = w_v;
    o_payload[SLOT_U - SLOT_AUDIO_LSB]        = i_user;
    o_payload[SLOT_C - SLOT_AUDIO_LSB]        = i_control;
    o_payload[SLOT_P - SLOT_AUDIO_LSB]        = ^{w_audio, w_v, i_user, i_control};
    if (!i_is_left)   o_preamble = PRE_W;
    else if (i_use_b) o_preamble = PRE_B;
    else              o_preamble = PRE_M;
  end
endmodule

// File: rtl/spdif_sub_frame_encoder_pb.sv
// S/PDIF sub-frame encoder: one-entry holding buffer, 64-cell sequencer,
// fill sub-frames with block tracking on underrun, and registered BMC output.
module spdif_sub_frame_encoder_pb
  import spdif_pkg::*;
#(
  parameter int AUDIO_WIDTH      = 24,
  parameter int FRAMES_PER_BLOCK = 192
) (
  input  logic                   clk128,
  input  logic                   reset_n,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic                   i_is_frame_start,
  input  logic                   i_is_left,
  input  logic [AUDIO_WIDTH-1:0] i_audio,
  input  logic                   i_validity,
  input  logic                   i_user,
  input  logic                   i_control,
  input  logic                   i_mute,
  output logic                   o_underrun,
  output logic                   spdif
);
  localparam int BLK_W = (FRAMES_PER_BLOCK > 1) ? $clog2(FRAMES_PER_BLOCK) : 1;

  state_t                 r_state;
  logic [5:0]             r_cell;
  logic [BLK_W-1:0]       r_blk;
  logic                   r_left;
  logic                   r_pol;
  logic                   r_spdif;
  logic                   r_underrun_p0;
  logic                   r_underrun;
  logic                   r_hold_full;
  logic                   r_hold_fs;
  logic                   r_hold_left;
  logic                   r_hold_v;
  logic                   r_hold_u;
  logic                   r_hold_c;
  logic                   r_hold_mute;
  logic [AUDIO_WIDTH-1:0] r_hold_audio;
  logic [27:0]            r_pay;
  logic [7:0]             r_pre;

  logic                   w_xfer;
  logic                   w_load;
  logic                   w_fill;
  logic                   w_ld_left;
  logic                   w_use_b;
  logic [BLK_W-1:0]       w_blk_adv;
  logic [BLK_W-1:0]       w_blk_next;
  logic [4:0]             w_pay_idx;
  logic                   w_spdif_nxt;
  logic [27:0]            w_payload;
  logic [7:0]             w_preamble;

  assign w_xfer    = i_valid && !r_hold_full;
  assign w_load    = (r_state == ST_IDLE) ? r_hold_full
                                          : (r_cell == 6'(CELLS_PER_SUBFRAME - 1));
  assign w_fill    = (r_state == ST_RUN) && !r_hold_full;
  assign w_ld_left = w_fill ? !r_left : r_hold_left;

  // The block counter advances once after every right sub-frame; a left
  // frame-start sample resynchronises it to the upstream block.
  assign w_blk_adv  = ((r_state == ST_RUN) && !r_left)
                      ? ((r_blk == BLK_W'(FRAMES_PER_BLOCK - 1)) ? '0 : r_blk + BLK_W'(1))
                      : r_blk;
  assign w_blk_next = (!w_fill && r_hold_left && r_hold_fs) ? '0 : w_blk_adv;
  assign w_use_b    = w_fill ? (w_ld_left && (w_blk_adv == '0)) : (r_hold_left && r_hold_fs);

  spdif_subframe_assembler #(
    .AUDIO_WIDTH(AUDIO_WIDTH)
  ) u_asm (
    .i_audio    (w_fill ? '0 : r_hold_audio),
    .i_validity (w_fill ? 1'b1 : r_hold_v),
    .i_user     (w_fill ? 1'b0 : r_hold_u),
    .i_control  (w_fill ? 1'b0 : r_hold_c),
    .i_mute     (w_fill ? 1'b0 : r_hold_mute),
    .i_is_left  (w_ld_left),
    .i_use_b    (w_use_b),
    .o_payload  (w_payload),
    .o_preamble (w_preamble)
  );

  assign w_pay_idx = r_cell[5:1] - 5'd4;

  // Cell 0 takes its reference level from the last cell just driven; cells
  // 1..7 reuse that level, captured into r_pol.
  always_comb begin
    w_spdif_nxt = r_spdif;
    if (r_state == ST_RUN) begin
      if (r_cell == 6'd0)      w_spdif_nxt = r_pre[7] ^ r_spdif;
      else if (r_cell < 6'd8)  w_spdif_nxt = r_pre[~r_cell[2:0]] ^ r_pol;
      else if (!r_cell[0])     w_spdif_nxt = !r_spdif;
      else                     w_spdif_nxt = r_spdif ^ r_pay[w_pay_idx];
    end
  end

  always_ff @(posedge clk128 or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_cell        <= 6'd0;
      r_blk         <= '0;
      r_left        <= 1'b0;
      r_pol         <= 1'b0;
      r_spdif       <= 1'b0;
      r_underrun_p0 <= 1'b0;
      r_underrun    <= 1'b0;
      r_hold_full   <= 1'b0;
    end else begin
      r_spdif       <= w_spdif_nxt;
      r_underrun_p0 <= w_load && w_fill;
      r_underrun    <= r_underrun_p0;
      if (r_state == ST_RUN) begin
        r_cell <= r_cell + 6'd1;
        if (r_cell == 6'd0) r_pol <= r_spdif;
      end
      if (w_xfer)                 r_hold_full <= 1'b1;
      else if (w_load && !w_fill) r_hold_full <= 1'b0;
      if (w_load) begin
        r_state <= ST_RUN;
        r_left  <= w_ld_left;
        r_blk   <= w_blk_next;
      end
    end
  end

  always_ff @(posedge clk128) begin
    if (w_xfer) begin
      r_hold_fs    <= i_is_frame_start;
      r_hold_left  <= i_is_left;
      r_hold_v     <= i_validity;
      r_hold_u     <= i_user;
      r_hold_c     <= i_control;
      r_hold_mute  <= i_mute;
      r_hold_audio <= i_audio;
    end
    if (w_load) begin
      r_pay <= w_payload;
      r_pre <= w_preamble;
    end
  end

  assign i_ready    = !r_hold_full;
  assign o_underrun = r_underrun;
  assign spdif      = r_spdif;
endmodule

// File: tb/tb_spdif_sub_frame_encoder_pb.sv
// Directed bench for the S/PDIF sub-frame encoder: 24-bit and 16-bit instances
// run in lockstep; outputs are logged per cycle and decoded per sub-frame.
module tb_spdif_sub_frame_encoder_pb;
  typedef struct packed {
    logic        left;
    logic        fs;
    logic        v;
    logic        u;
    logic        c;
    logic        mute;
    logic [23:0] aud;
    logic [15:0] aud16;
  } smp_t;

  localparam logic [7:0] EXP_B = 8'b11101000;
  localparam logic [7:0] EXP_M = 8'b11100010;
  localparam logic [7:0] EXP_W = 8'b11100100;

  logic        clk128 = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_is_frame_start = 1'b0;
  logic        i_is_left = 1'b0;
  logic        i_validity = 1'b0;
  logic        i_user = 1'b0;
  logic        i_control = 1'b0;
  logic        i_mute = 1'b0;
  logic [23:0] i_audio = '0;
  logic [15:0] i_audio16 = '0;
  logic        i_ready, o_underrun, spdif;
  logic        i_ready16, o_underrun16, spdif16;

  smp_t q_in[$];
  logic lg_sp[$];
  logic lg_sp16[$];
  logic lg_und[$];
  logic lg_und16[$];
  logic lg_rdy[$];
  int   first_drv = -1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk128 = ~clk128;

  spdif_sub_frame_encoder_pb #(.AUDIO_WIDTH(24), .FRAMES_PER_BLOCK(192)) dut (
    .clk128(clk128), .reset_n(reset_n), .i_valid(i_valid), .i_ready(i_ready),
    .i_is_frame_start(i_is_frame_start), .i_is_left(i_is_left), .i_audio(i_audio),
    .i_validity(i_validity), .i_user(i_user), .i_control(i_control), .i_mute(i_mute),
    .o_underrun(o_underrun), .spdif(spdif)
  );

  spdif_sub_frame_encoder_pb #(.AUDIO_WIDTH(16), .FRAMES_PER_BLOCK(192)) dut16 (
    .clk128(clk128), .reset_n(reset_n), .i_valid(i_valid), .i_ready(i_ready16),
    .i_is_frame_start(i_is_frame_start), .i_is_left(i_is_left), .i_audio(i_audio16),
    .i_validity(i_validity), .i_user(i_user), .i_control(i_control), .i_mute(i_mute),
    .o_underrun(o_underrun16), .spdif(spdif16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One logged negedge per cycle; a queued sample is offered whenever ready is seen high.
  task automatic run(input int n);
    smp_t s;
    for (int i = 0; i < n; i++) begin
      @(negedge clk128);
      lg_sp.push_back(spdif);
      lg_sp16.push_back(spdif16);
      lg_und.push_back(o_underrun);
      lg_und16.push_back(o_underrun16);
      lg_rdy.push_back(i_ready);
      i_valid = 1'b0;
      if (i_ready && q_in.size() > 0) begin
        s = q_in.pop_front();
        i_is_left        = s.left;
        i_is_frame_start = s.fs;
        i_validity       = s.v;
        i_user           = s.u;
        i_control        = s.c;
        i_mute           = s.mute;
        i_audio          = s.aud;
        i_audio16        = s.aud16;
        i_valid          = 1'b1;
        if (first_drv < 0) first_drv = lg_sp.size() - 1;
      end
    end
  endtask

  task automatic new_test();
    i_valid = 1'b0;
    q_in.delete();
    @(negedge clk128);
    reset_n = 1'b0;
    repeat (2) @(negedge clk128);
    check("rst_spdif", 32'(spdif), 32'd0);
    check("rst_ready", 32'(i_ready), 32'd1);
    check("rst_ready16", 32'(i_ready16), 32'd1);
    check("rst_underrun", 32'(o_underrun), 32'd0);
    reset_n = 1'b1;
    lg_sp.delete(); lg_sp16.delete(); lg_und.delete(); lg_und16.delete(); lg_rdy.delete();
    first_drv = -1;
  endtask

  function automatic void decode(input int base, input bit w16, output logic [7:0] pre,
                                 output logic [27:0] pay, output int berr);
    logic c[64];
    logic prev;
    prev = w16 ? lg_sp16[base-1] : lg_sp[base-1];
    for (int i = 0; i < 64; i++) c[i] = w16 ? lg_sp16[base+i] : lg_sp[base+i];
    berr = 0;
    for (int i = 0; i < 8; i++) pre[7-i] = c[i] ^ prev;
    for (int s = 4; s < 32; s++) begin
      if (c[2*s] == c[2*s-1]) berr++;
      pay[s-4] = c[2*s] ^ c[2*s+1];
    end
  endfunction

  function automatic logic [27:0] exp_pay(input logic [23:0] aud, input logic v, u, c, mute);
    logic [23:0] a;
    logic        vv;
    a  = mute ? 24'd0 : aud;
    vv = v | mute;
    return {^{a, vv, u, c}, c, u, vv, a};
  endfunction

  function automatic int cnt_sp(input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) n += int'(lg_sp[i]);
    return n;
  endfunction

  function automatic int cnt_und(input int a, input int b);
    int n = 0;
    for (int i = a; i < b; i++) n += int'(lg_und[i]);
    return n;
  endfunction

  initial begin
    logic [7:0]  pre;
    logic [27:0] pay;
    int          berr, base, tries;
    int          pre_err, pay_err, bmc_err, b_cnt;
    logic [7:0]  epre;
    logic [27:0] epay;
    smp_t        s;
    smp_t        stream[$];

    // Single left frame-start sample, then starvation into fill sub-frames.
    new_test();
    q_in.push_back('{left:1'b1, fs:1'b1, v:1'b0, u:1'b0, c:1'b0, mute:1'b0,
                     aud:24'h000001, aud16:16'h8001});
    run(3 + 64*4 + 2);
    base = first_drv + 3;
    check("idle_spdif_zero", 32'(cnt_sp(0, base)), 32'd0);
    check("ready_fall", 32'(lg_rdy[first_drv+1]), 32'd0);
    check("ready_rise", 32'(lg_rdy[first_drv+2]), 32'd1);
    decode(base, 1'b0, pre, pay, berr);
    check("sf0_pre", 32'(pre), 32'(EXP_B));
    check("sf0_pay", 32'(pay), 32'h8000001);
    check("sf0_bmc", 32'(berr), 32'd0);
    decode(base, 1'b1, pre, pay, berr);
    check("w16_pre", 32'(pre), 32'(EXP_B));
    check("w16_pay", 32'(pay), 32'h0800100);
    check("und_quiet_sf0", 32'(cnt_und(0, base + 64)), 32'd0);
    check("und_at_cell0", 32'(lg_und[base+64]), 32'd1);
    check("und16_at_cell0", 32'(lg_und16[base+64]), 32'd1);
    check("und_one_pulse", 32'(cnt_und(base + 64, base + 128)), 32'd1);
    decode(base + 64, 1'b0, pre, pay, berr);
    check("fill1_pre", 32'(pre), 32'(EXP_W));
    check("fill1_pay", 32'(pay), 32'h9000000);
    decode(base + 128, 1'b0, pre, pay, berr);
    check("fill2_pre", 32'(pre), 32'(EXP_M));
    check("fill2_pay", 32'(pay), 32'h9000000);
    decode(base + 192, 1'b0, pre, pay, berr);
    check("fill3_pre", 32'(pre), 32'(EXP_W));
    check("fill3_bmc", 32'(berr), 32'd0);

    // Gap-free stream of 384 alternating samples; the fill after it must carry B.
    new_test();
    for (int i = 0; i < 384; i++) begin
      s.left  = (i % 2 == 0);
      s.fs    = (i == 0);
      s.v     = i[2];
      s.u     = i[3];
      s.c     = i[4];
      s.mute  = (i % 50 == 7);
      s.aud   = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A};
      s.aud16 = {i[7:0], 8'hC3};
      q_in.push_back(s);
      stream.push_back(s);
    end
    run(3 + 64*385 + 4);
    base = first_drv + 3;
    pre_err = 0; pay_err = 0; bmc_err = 0; b_cnt = 0;
    for (int j = 0; j < 385; j++) begin
      decode(base + 64*j, 1'b0, pre, pay, berr);
      bmc_err += berr;
      if (j == 384) begin
        epre = EXP_B;
        epay = 28'h9000000;
      end else begin
        epre = (j % 2 == 1) ? EXP_W : ((j == 0) ? EXP_B : EXP_M);
        epay = exp_pay(stream[j].aud, stream[j].v, stream[j].u, stream[j].c, stream[j].mute);
        if (pre == EXP_B) b_cnt++;
      end
      if (pre != epre) pre_err++;
      if (pay != epay) pay_err++;
    end
    check("stream_pre_errs", 32'(pre_err), 32'd0);
    check("stream_pay_errs", 32'(pay_err), 32'd0);
    check("stream_bmc_errs", 32'(bmc_err), 32'd0);
    check("stream_b_count", 32'(b_cnt), 32'd1);
    check("stream_no_underrun", 32'(cnt_und(0, base + 64*384)), 32'd0);
    check("stream_fill_und", 32'(lg_und[base + 64*384]), 32'd1);
    decode(base + 64*384, 1'b0, pre, pay, berr);
    check("sf384_pre", 32'(pre), 32'(EXP_B));

    // Mute forces silent audio and V=1 while U passes through.
    new_test();
    q_in.push_back('{left:1'b0, fs:1'b0, v:1'b0, u:1'b1, c:1'b0, mute:1'b1,
                     aud:24'hFFFFFF, aud16:16'hFFFF});
    run(3 + 64 + 2);
    base = first_drv + 3;
    decode(base, 1'b0, pre, pay, berr);
    check("mute_pre", 32'(pre), 32'(EXP_W));
    check("mute_pay", 32'(pay), 32'h3000000);
    check("mute_parity", 32'(^pay), 32'd0);
    decode(base, 1'b1, pre, pay, berr);
    check("mute16_pay", 32'(pay), 32'h3000000);

    // Asynchronous reset in mid sub-frame with the holding buffer full.
    new_test();
    q_in.push_back('{left:1'b1, fs:1'b1, v:1'b0, u:1'b0, c:1'b0, mute:1'b0,
                     aud:24'hABCDEF, aud16:16'hABCD});
    q_in.push_back('{left:1'b0, fs:1'b0, v:1'b0, u:1'b1, c:1'b1, mute:1'b0,
                     aud:24'h13579B, aud16:16'h1357});
    run(3 + 31);
    check("pre_rst_ready", 32'(i_ready), 32'd0);
    tries = 0;
    while (spdif !== 1'b1 && tries < 4) begin
      run(1);
      tries++;
    end
    check("pre_rst_high", 32'(spdif), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_spdif", 32'(spdif), 32'd0);
    check("async_ready", 32'(i_ready), 32'd1);
    new_test();
    q_in.push_back('{left:1'b1, fs:1'b1, v:1'b1, u:1'b0, c:1'b0, mute:1'b0,
                     aud:24'h800000, aud16:16'h8000});
    run(3 + 128 + 2);
    base = first_drv + 3;
    check("restart_idle", 32'(cnt_sp(0, base)), 32'd0);
    decode(base, 1'b0, pre, pay, berr);
    check("restart_pre", 32'(pre), 32'(EXP_B));
    check("restart_pay", 32'(pay), 32'h1800000);
    decode(base + 64, 1'b0, pre, pay, berr);
    check("restart_fill_pay", 32'(pay), 32'h9000000);
    check("restart_fill_und", 32'(lg_und[base+64]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/spdif_sub_frame_encoder_pb.md
Name: spdif_sub_frame_encoder_pb

Overview:
- Parametrised successor of the S/PDIF sub-frame encoder. Accepts one audio sample per valid/ready handshake and emits a complete biphase-mark-coded (BMC) 32-slot sub-frame, one BMC cell per clk128 cycle.
- New relative to the current encoder:
  - Configurable audio width.
  - Validity and mute inputs.
  - A one-entry holding buffer for gap-free back-to-back streaming.
  - Autonomous fill sub-frames with internal block tracking on underrun.
- Sits between the sample FIFO/channel-status mux and the S/PDIF output pin.

Parameters:
- AUDIO_WIDTH, 24, sample width; legal values 16..24. The sample is MSB-aligned at slot 27, and unused LSB slots are 0.
- FRAMES_PER_BLOCK, 192, frames per channel-status block. Used for B-preamble placement in fill sub-frames.

Ports:
- clk128  in  1  cell clock, 128 x fs
- reset_n  in  1  asynchronous, active-low reset
- i_valid  in  1  sample valid
- i_ready  out  1  holding buffer empty
- i_is_frame_start  in  1  sample starts a block (B preamble); meaningful only with i_is_left=1
- i_is_left  in  1  1 = channel A (M/B preamble), 0 = channel B (W preamble)
- i_audio  in  AUDIO_WIDTH  PCM sample
- i_validity  in  1  V bit
- i_user  in  1  U bit
- i_control  in  1  C (channel-status) bit
- i_mute  in  1  force silence, sampled at sub-frame load
- o_underrun  out  1  one-cycle pulse when a fill sub-frame starts
- spdif  out  1  BMC output, registered

Behaviour:
- Reset (async assert, sync release). All of the following are cleared:
  - spdif=0, o_underrun=0, i_ready=1.
  - State IDLE, cell counter 0, block counter 0, holding buffer empty.
- States: IDLE -> RUN. RUN never returns to IDLE except via reset.
- Handshake:
  - Transfer occurs when i_valid && i_ready.
  - The holding register captures all i_* fields; i_ready falls the next cycle.
  - Holding empties when its contents are moved into the shift register; i_ready rises the following cycle.
- IDLE: spdif held 0. A transfer at cycle t loads the shift register at t+1; cell 0 appears on spdif at t+2; state becomes RUN.
- RUN: a 6-bit cell counter runs 0..63 continuously and wraps 63->0. At each wrap the next sub-frame loads:
  - holding full: load from holding, clear holding, o_underrun stays 0.
  - holding empty: load a fill sub-frame and pulse o_underrun for one cycle, aligned with cell 0.
- Simultaneous wrap and transfer: a transfer on the wrap cycle is not used at that wrap. The holding register cannot load and unload in the same cycle because i_ready=0 while full.
- Fill sub-frame:
  - audio=0, V=1, U=0, C=0.
  - Channel is the opposite of the previous sub-frame.
  - If left and the block counter is 0, the preamble is B; otherwise M (left) or W (right).
- Block counter (0..FRAMES_PER_BLOCK-1):
  - Loading a left sub-frame with i_is_frame_start=1 sets it to 0.
  - Otherwise it increments with wrap after each right sub-frame.
- Mute: if i_mute=1 when a sample is moved from holding, audio slots are forced to 0 and V=1. U and C are passed through.
- Slot map:
  - Slots 0-3 (cells 0-7): preamble.
  - Slots 4-27: audio, LSB first.
  - Slot 28: V. Slot 29: U. Slot 30: C. Slot 31: P.
- Parity: P = XOR of slots 4..30, giving even parity over slots 4..31.
- Preamble cells, for the case where the last cell of the previous sub-frame was 0:
  - B = 11101000, M = 11100010, W = 11100100.
  - Invert all eight cells if that last cell was 1.
  - The first sub-frame after reset is treated as preceded by 0.
- Data slots: the first cell of each slot inverts the previous level. The second cell inverts again for a 1 bit and holds for a 0 bit.
- Sub-frame length is exactly 64 cycles in RUN. There are no gaps and no dropped samples while upstream keeps holding refilled within 64 cycles.

Decomposition:
- Package spdif_pkg holds:
  - Preamble constants PRE_B, PRE_M, PRE_W (8-bit).
  - Slot indices SLOT_AUDIO_LSB=4, SLOT_V=28, SLOT_U=29, SLOT_C=30, SLOT_P=31.
  - CELLS_PER_SUBFRAME=64.
- One sub-module, spdif_subframe_assembler (combinational): builds the 28-bit payload, including alignment, mute and parity, plus the preamble select.
- Cell sequencing, buffering, fill logic and BMC output stay in the top module.

Test Plan:
- Reset then a single transfer (left, frame_start=1, audio=24'h000001, V=U=C=0):
  - spdif=0 until t+2.
  - Cells 0-7 = 11101000.
  - Slot 4 decodes 1, slots 5-31 decode 0 except P=1.
  - Decoded sub-frame length is 64 cycles.
- Continuous stream of 384 alternating L/R samples with frame_start on the first: zero o_underrun pulses, and B preambles exactly at sub-frames 0 and 384.
- AUDIO_WIDTH=16, audio=16'h8001: decoded slots 4-11 = 0, slot 12 = 1, slot 27 = 1, P = 0.
- Stop i_valid after a left sample:
  - The next sub-frame is fill W with V=1 and audio 0.
  - o_underrun pulses once, aligned with cell 0.
  - The following sub-frames are M, W, ... and the counter places B after 192 frames.
- i_mute=1 with audio=24'hFFFFFF, U=1: audio decodes 0, V=1, U=1; parity is even over slots 4..31.
- Assert reset_n low mid-sub-frame (cell 30): spdif=0 and i_ready=1 immediately (async); after release the block returns to IDLE and restarts cleanly on the next transfer.
